logic_unit_arbiter: RTL
=======================

Name: logic_unit_arbiter

Overview:
- Shares one 3-input/3-output combinational logic unit (inputs A,B,C; outputs X,Y,Z) between N_REQ requesters.
- Round-robin arbitration with a req/ack handshake per requester.
- Drives the unit's inputs from a registered operand, waits a programmable settle time, captures X,Y,Z, and returns the result tagged with the requester id.
- Sits between the requesting control blocks and the logic unit instance; the unit stays purely combinational and outside this block.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester id width; must equal clog2(N_REQ).
- SETTLE_CYCLES, 1, cycles the unit inputs are held before outputs are sampled (1..15).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester request; held high until the matching ack.
- req_abc  in  3*N_REQ  operand {A,B,C} of requester i at bits [3i+2:3i]; stable while req[i]=1.
- ack  out  N_REQ  one-hot, one-cycle pulse marking completion for requester i.
- rsp_valid  out  1  result valid, same cycle as ack.
- rsp_id  out  ID_W  index of the completed requester.
- rsp_xyz  out  3  captured {X,Y,Z}.
- fu_abc  out  3  registered {A,B,C} driven to the logic unit.
- fu_xyz  in  3  {X,Y,Z} returned from the logic unit.
- busy  out  1  high in DRIVE and RESP.
- op_count  out  CNT_W  completed operations; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync deassert handled upstream) clears everything: state=IDLE, ack=0, rsp_valid=0, rsp_id=0, rsp_xyz=0, fu_abc=000, busy=0, op_count=0, rr_ptr=0, settle counter=0.
- States: IDLE, DRIVE, RESP.
- IDLE:
  - If any req bit is high, the winner is the first set bit searching from rr_ptr upward with wrap.
  - On that edge: latch winner id; fu_abc <= req_abc[winner]; cnt <= SETTLE_CYCLES-1; rr_ptr <= (winner+1) mod N_REQ; go to DRIVE.
  - No req: stay in IDLE, fu_abc holds its last value.
- DRIVE:
  - fu_abc is held constant.
  - cnt!=0: cnt decrements.
  - cnt==0: on that edge rsp_xyz <= fu_xyz, rsp_id <= id, rsp_valid <= 1, ack[id] <= 1, op_count++, go to RESP.
- RESP:
  - Lasts exactly one cycle; ack and rsp_valid are high only in this cycle.
  - Next edge: clear ack and rsp_valid, go to IDLE.
  - rsp_xyz and rsp_id hold until the next capture.
- Latency: req sampled high in IDLE at edge E, ack high in the cycle following edge E+SETTLE_CYCLES. With default 1: ack visible 2 cycles after the sampling edge.
- Throughput: one operation per SETTLE_CYCLES+2 cycles.
- Requester rule: deassert req (or present a new operand) on the edge where ack is sampled high. IDLE therefore never re-grants a completed request.
- Operand is captured at grant. Changes to req_abc or a req drop during DRIVE do not affect the in-flight operation, which still completes and acks.
- New req arriving during DRIVE/RESP waits; no request is lost while held high.
- Fairness: a continuously requesting set is served in strict rotation; a requester waits at most N_REQ-1 other operations.
- Only one ack bit is ever high at a time.
- op_count wraps from all-ones to 0 without a flag.
- rst_n asserted mid-operation aborts it immediately: no ack, no count increment; after release the abandoned requester, if still requesting, is re-arbitrated from rr_ptr=0.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'b00, DRIVE=2'b01, RESP=2'b10);
  - operand/result width constant (3);
  - default SETTLE_CYCLES.
- One natural sub-module: rr_pick, a combinational round-robin priority selector (inputs req, rr_ptr; outputs any_req, winner id).
- FSM, datapath registers and counter stay in the top.

Test Plan:
- The bench models the logic unit with these vectors ({A,B,C} -> {X,Y,Z}): 010 -> 011, 110 -> 111, 101 -> 101, 001 -> 000.
- Reset: drive rst_n=0 with random req -> ack=0, rsp_valid=0, fu_abc=000, op_count=0, busy=0 throughout.
- Single request: req[0]=1, req_abc[0]=010 -> fu_abc=010 for 1 cycle, then ack=0001, rsp_valid=1, rsp_id=0, rsp_xyz=011, op_count=1.
- Round-robin: req=1111 held high with operands 010,110,101,001 (ids 0..3) -> acks in order 0,1,2,3,0 with rsp_xyz 011,111,101,000,011; ack pulses 3 cycles apart.
- Settle and stability: SETTLE_CYCLES=3, req[2]=1 with operand 101, then change req_abc[2] to 001 one cycle after grant -> fu_abc stays 101 for 3 cycles; rsp_xyz=101, rsp_id=2.
- Reset mid-operation: assert rst_n=0 during DRIVE for requester 1 -> no ack pulse, op_count stays 0; after release, req[1] still high -> served; ack[1] returns the correct result.
- Counter wrap: CNT_W=2, 5 back-to-back operations -> op_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the logic unit arbiter: FSM encoding, operand width
// and the default settle time of the shared combinational unit.
package logic_unit_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_RESP  = 2'b10
    } state_e;

    localparam int OPW               = 3;
    localparam int DEF_SETTLE_CYCLES = 1;
    localparam int SETTLE_W          = 4;

endpackage

// File: rtl/logic_unit_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above rr_ptr,
// wrapping past the top index.
module logic_unit_arbiter_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic             any_req,
    output logic [ID_W-1:0]  winner
);

    logic [ID_W-1:0] idx_s;

    // Scan offsets from farthest to nearest so the nearest set bit wins last.
    always_comb begin
        any_req = 1'b0;
        winner  = {ID_W{1'b0}};
        idx_s   = {ID_W{1'b0}};
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx_s = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (req[idx_s]) begin
                any_req = 1'b1;
                winner  = idx_s;
            end else begin
                any_req = any_req;
                winner  = winner;
            end
        end
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one external 3-in/3-out combinational logic unit
// between N_REQ requesters; results return tagged with the requester id.
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int ID_W          = 2,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [OPW*N_REQ-1:0] req_abc,
    output logic [N_REQ-1:0]     ack,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [OPW-1:0]       rsp_xyz,
    output logic [OPW-1:0]       fu_abc,
    input  logic [OPW-1:0]       fu_xyz,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);

    localparam logic [N_REQ-1:0] ACK_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    state_e                state_r;
    logic [ID_W-1:0]       id_r;
    logic [ID_W-1:0]       rr_ptr_r;
    logic [SETTLE_W-1:0]   cnt_r;
    logic [ID_W-1:0]       win_s;
    logic [ID_W-1:0]       next_ptr_s;
    logic                  any_req_s;
    logic [OPW-1:0]        operand_s [N_REQ];

    // Unpack the flat operand bus into one entry per requester.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            operand_s[i] = req_abc[OPW*i +: OPW];
        end
    end

    // Pointer moves just past the winner so it gets lowest priority next time.
    always_comb begin
        if (win_s == ID_W'(N_REQ - 1)) begin
            next_ptr_s = {ID_W{1'b0}};
        end else begin
            next_ptr_s = win_s + ID_W'(1);
        end
    end

    logic_unit_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req     (req),
        .rr_ptr  (rr_ptr_r),
        .any_req (any_req_s),
        .winner  (win_s)
    );

    // Grant / settle / respond sequencer with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            id_r      <= {ID_W{1'b0}};
            rr_ptr_r  <= {ID_W{1'b0}};
            cnt_r     <= {SETTLE_W{1'b0}};
            ack       <= {N_REQ{1'b0}};
            rsp_valid <= 1'b0;
            rsp_id    <= {ID_W{1'b0}};
            rsp_xyz   <= {OPW{1'b0}};
            fu_abc    <= {OPW{1'b0}};
            busy      <= 1'b0;
            op_count  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        id_r     <= win_s;
                        fu_abc   <= operand_s[win_s];
                        cnt_r    <= SETTLE_W'(SETTLE_CYCLES - 1);
                        rr_ptr_r <= next_ptr_s;
                        busy     <= 1'b1;
                        state_r  <= ST_DRIVE;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_r != {SETTLE_W{1'b0}}) begin
                        cnt_r     <= cnt_r - SETTLE_W'(1);
                    end else begin
                        rsp_xyz   <= fu_xyz;
                        rsp_id    <= id_r;
                        rsp_valid <= 1'b1;
                        ack       <= ACK_ONE << id_r;
                        op_count  <= op_count + CNT_W'(1);
                        state_r   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    ack       <= {N_REQ{1'b0}};
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    ack       <= {N_REQ{1'b0}};
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
